// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx
// Serial telemetry framer with a built-in UART-style serializer. A start
// request snapshots the payload and sends SOF, each field, an optional XOR
// checksum, and EOF. Each character is a start bit, DATA_BITS data bits
// (LSB first), a parity bit and a stop bit.
//
// Handshake: start is a request that is only looked at in IDLE. The edge that
// accepts it also captures fields/checksum_en. busy is high from the next
// cycle until the final stop bit has been sent. done is a one-cycle pulse in
// the cycle after that stop bit, and busy is already low in that cycle.
// Requests that arrive while busy, or during the done cycle, are dropped.
module telemetry_frame_tx #(
    parameter int N_FIELDS   = 5,
    parameter int DATA_BITS  = 7,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY_ODD = 1,
    parameter logic [DATA_BITS-1:0] SOF_CHAR = DATA_BITS'(7'h02),
    parameter logic [DATA_BITS-1:0] EOF_CHAR = DATA_BITS'(7'h0A)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          checksum_en,
    input  logic [N_FIELDS*DATA_BITS-1:0] fields,
    output logic                          saida_serial,
    output logic                          busy,
    output logic                          done,
    output logic [4:0]                    db_char,
    output logic [2:0]                    db_estado
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [DW-1:0] BIT_LAST  = DW'(DATA_BITS - 1);
    // Index of the last character, with and without the checksum.
    // Without the checksum, this is also the index where the checksum goes
    // when it is present.
    localparam logic [4:0] LAST_NO_CS   = 5'(N_FIELDS + 1);
    localparam logic [4:0] LAST_WITH_CS = 5'(N_FIELDS + 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [DW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    // Frame snapshot: taken when a request is accepted, so payload changes
    // during the frame cannot tear it.
    logic [DATA_BITS-1:0] snap [N_FIELDS];
    logic                 snap_cs;
    logic [DATA_BITS-1:0] cs_char;

    logic [DATA_BITS-1:0] fields_xor;
    logic [DATA_BITS-1:0] cur_char;
    logic [4:0]           char_last;
    logic                 parity_bit;
    logic                 baud_end;

    assign db_estado = state;
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign char_last = snap_cs ? LAST_WITH_CS : LAST_NO_CS;

    // XOR of the live payload words; registered as the checksum on accept.
    always_comb begin
        fields_xor = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            fields_xor = fields_xor ^ fields[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Select the character for the current index from the snapshot.
    always_comb begin
        cur_char = EOF_CHAR;
        if (db_char == 5'd0) begin
            cur_char = SOF_CHAR;
        end else if (db_char <= 5'(N_FIELDS)) begin
            for (int i = 0; i < N_FIELDS; i++) begin
                if (db_char == 5'(i + 1)) begin
                    cur_char = snap[i];
                end
            end
        end else if (snap_cs && (db_char == LAST_NO_CS)) begin
            cur_char = cs_char;
        end
    end

    // Odd parity makes data+parity hold an odd number of ones; even parity
    // makes it hold an even number.
    always_comb begin
        parity_bit = (PARITY_ODD != 0) ? ~(^cur_char) : (^cur_char);
    end

    // Capture the payload, checksum enable and checksum on an accepted request.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            for (int i = 0; i < N_FIELDS; i++) begin
                snap[i] <= fields[i*DATA_BITS +: DATA_BITS];
            end
            snap_cs <= checksum_en;
            cs_char <= fields_xor;
        end
    end

    // Framing FSM: bit/char sequencing with registered line, busy and done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            db_char      <= '0;
            saida_serial <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= START_BIT;
                        busy         <= 1'b1;
                        saida_serial <= 1'b0;
                        baud_cnt     <= '0;
                        db_char      <= '0;
                    end
                end
                START_BIT: begin
                    if (baud_end) begin
                        baud_cnt     <= '0;
                        bit_cnt      <= '0;
                        saida_serial <= cur_char[0];
                        shreg        <= cur_char >> 1;
                        state        <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            saida_serial <= parity_bit;
                            state        <= PARITY;
                        end else begin
                            bit_cnt      <= bit_cnt + 1'b1;
                            saida_serial <= shreg[0];
                            shreg        <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt     <= '0;
                        saida_serial <= 1'b1;
                        state        <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (db_char == char_last) begin
                            db_char <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            db_char      <= db_char + 1'b1;
                            saida_serial <= 1'b0;
                            state        <= START_BIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Bench for telemetry_frame_tx: scoreboard of expected characters and done
// times, with a line monitor that decodes every character bit by bit.
module tb_telemetry_frame_tx;

    localparam int NF = 4;
    localparam int DB = 7;
    localparam int BD = 4;
    localparam int FW = NF * DB;
    localparam logic [DB-1:0] SOF = 7'h02;
    localparam logic [DB-1:0] EOF = 7'h0A;
    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          checksum_en = 1'b0;
    logic [FW-1:0] fields = '0;
    logic          saida_serial, busy, done;
    logic [4:0]    db_char;
    logic [2:0]    db_estado;

    // Second instance: 8-bit even-parity configuration.
    logic       start8 = 1'b0;
    logic [7:0] fields8 = 8'hFF;
    logic       line8, busy8, done8;
    logic [4:0] dbc8;
    logic [2:0] dbe8;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    logic [DB-1:0] exp_q[$];
    int            done_q[$];

    telemetry_frame_tx #(.N_FIELDS(NF), .DATA_BITS(DB), .BAUD_DIV(BD)) dut (
        .clock(clock), .reset(reset), .start(start), .checksum_en(checksum_en),
        .fields(fields), .saida_serial(saida_serial), .busy(busy), .done(done),
        .db_char(db_char), .db_estado(db_estado));

    telemetry_frame_tx #(.N_FIELDS(1), .DATA_BITS(8), .BAUD_DIV(BD), .PARITY_ODD(0),
                         .SOF_CHAR(8'h02), .EOF_CHAR(8'h0A)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .checksum_en(1'b0),
        .fields(fields8), .saida_serial(line8), .busy(busy8), .done(done8),
        .db_char(dbc8), .db_estado(dbe8));

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clock); while (cyc < n);
    endtask

    function automatic int frame_len(input logic cs);
        return (NF + 2 + int'(cs)) * (DB + 3) * BD;
    endfunction

    // Reference model: the character list of a frame and its done cycle.
    task automatic push_model(input logic [FW-1:0] f, input logic cs, input int p);
        logic [DB-1:0] x;
        x = '0;
        exp_q.push_back(SOF);
        for (int i = 0; i < NF; i++) begin
            exp_q.push_back(f[i*DB +: DB]);
            x = x ^ f[i*DB +: DB];
        end
        if (cs) exp_q.push_back(x);
        exp_q.push_back(EOF);
        done_q.push_back(p + frame_len(cs));
    endtask

    // Called at a negedge; returns the cycle number of the accepting edge.
    task automatic do_start(input logic [FW-1:0] f, input logic cs, output int p);
        fields = f;
        checksum_en = cs;
        start = 1'b1;
        push_model(f, cs, cyc + 1);
        @(posedge clock);
        #1;
        p = cyc;
        start = 1'b0;
    endtask

    // Line monitor: decodes characters and checks done timing.
    logic [DB+2:0] mon_bits;
    logic          mon_obs;
    logic          mon_active = 1'b0;
    int            mon_bit = 0;
    int            mon_sub = 0;

    always @(negedge clock) begin
        logic [DB-1:0] c;
        logic          par;
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                if (saida_serial !== mon_bits[mon_bit]) mon_obs = saida_serial;
                mon_sub++;
            end else if (saida_serial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    par = ($countones(c) % 2) == 0;
                    mon_bits = {1'b1, par, c, 1'b0};
                    mon_active = 1'b1;
                    mon_bit = 0;
                    mon_sub = 1;
                    mon_obs = mon_bits[0];
                    if (saida_serial !== mon_bits[0]) mon_obs = saida_serial;
                end
            end
            if (mon_active && mon_sub == BD) begin
                check("line_bit", mon_obs, mon_bits[mon_bit]);
                mon_sub = 0;
                mon_bit++;
                if (mon_bit == DB + 3) mon_active = 1'b0;
                else mon_obs = mon_bits[mon_bit];
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("done_busy_low", busy, 0);
                    check("done_line_high", saida_serial, 1);
                end
            end else if (done_q.size() > 0 && cyc == done_q[0]) begin
                check("missing_done", done, 1);
            end
        end
    end

    // Stimulus.
    initial begin
        int p;
        int p2;
        logic [FW-1:0] f;
        logic cs;

        repeat (3) @(negedge clock);
        check("rst_line", saida_serial, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_db_char", db_char, 0);
        check("rst_db_estado", db_estado, IDLE_CODE);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_cyc(cyc + 3);

        // Frame 1: checksum on, payload changes mid-frame, extra start ignored.
        do_start({7'h08, 7'h04, 7'h02, 7'h01}, 1'b1, p);
        wait_cyc(p);
        check("busy_at_t1", busy, 1);
        wait_cyc(p + 20);
        check("db_char_0", db_char, 0);
        wait_cyc(p + 49);
        fields = {NF{7'h7F}};
        checksum_en = 1'b0;
        for (int k = 1; k < 7; k++) begin
            wait_cyc(p + k * 40 + 20);
            check("db_char_k", db_char, k);
            check("busy_mid", busy, 1);
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
        end

        // Start held across the DONE cycle (ignored) into IDLE (accepted).
        wait_cyc(p + 279);
        @(posedge clock);
        #1;
        fields = {7'h08, 7'h04, 7'h02, 7'h01};
        checksum_en = 1'b0;
        start = 1'b1;
        p2 = p + 282;
        push_model(fields, 1'b0, p2);
        wait_cyc(p + 281);
        check("idle_after_done", busy, 0);
        check("idle_db_char", db_char, 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_cyc(p2);
        check("busy_frame2", busy, 1);
        wait_cyc(p2 + frame_len(1'b0) + 2);

        // Reset in the middle of a frame, then reset together with start.
        do_start({7'h11, 7'h22, 7'h33, 7'h44}, 1'b1, p);
        wait_cyc(p + 35);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        wait_cyc(p + 37);
        check("mid_rst_line", saida_serial, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_estado", db_estado, IDLE_CODE);
        check("mid_rst_db_char", db_char, 0);
        start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        wait_cyc(cyc);
        check("rst_start_busy", busy, 0);
        wait_cyc(cyc + 60);
        check("rst_quiet_busy", busy, 0);

        // Randomized frames with payload churn during transmission.
        for (int r = 0; r < 8; r++) begin
            wait_cyc(cyc + $urandom_range(1, 4));
            f = FW'($urandom());
            cs = 1'($urandom_range(0, 1));
            do_start(f, cs, p);
            wait_cyc(p + $urandom_range(5, 200));
            fields = FW'($urandom());
            checksum_en = ~cs;
            wait_cyc(p + frame_len(cs));
        end
        wait_cyc(cyc + 4);

        // 8-bit even parity: frame 02, FF, 0A with 11-bit characters.
        begin
            logic [7:0] ch8 [3];
            logic [10:0] bits8;
            ch8[0] = 8'h02;
            ch8[1] = 8'hFF;
            ch8[2] = 8'h0A;
            start8 = 1'b1;
            @(posedge clock);
            #1;
            p = cyc;
            start8 = 1'b0;
            for (int k = 0; k < 3; k++) begin
                bits8 = {1'b1, 1'(($countones(ch8[k]) % 2) != 0), ch8[k], 1'b0};
                for (int b = 0; b < 11; b++) begin
                    wait_cyc(p + (k * 11 + b) * BD + 1);
                    check("line8_bit", line8, bits8[b]);
                end
            end
            wait_cyc(p + 3 * 11 * BD - 1);
            check("done8_early", done8, 0);
            check("busy8_last", busy8, 1);
            wait_cyc(p + 3 * 11 * BD);
            check("done8", done8, 1);
            check("busy8_done", busy8, 0);
        end

        wait_cyc(cyc + 10);
        check("chars_left", exp_q.size(), 0);
        check("dones_left", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
